fp_wb_arbiter: RTL and testbench

FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

---
 rtl/fp_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_fp_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter
//   Round-robin arbiter that collects intermediate FP results from NUM_UNITS
//   producers (madd, mul, div/sqrt) and hands them one at a time to the
//   normalize/round stage.
//
//   Build option: define FP_WB_ARB_SKID_EN to put a 2-entry FIFO between
//   arbitration and the output. This removes the combinational path from
//   out_ready to unit_ack. Without the macro there is a single output
//   register, and acceptance depends on out_ready in the same cycle.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   unit_done     : per-producer "result pending"
//   unit_id       : per-producer id, slot i at [i*ID_W +: ID_W]
//   unit_payload  : per-producer result, slot i at [i*PAYLOAD_W +: PAYLOAD_W]
//   unit_ack      : one-hot acceptance of a producer result
//   out_valid     : result presented to the round stage
//   out_id        : id of the presented result
//   out_payload   : the presented result
//   out_unit      : index of the producer that supplied the result
//   out_ready     : round stage consumes when out_valid && out_ready
module fp_wb_arbiter #(
  parameter int NUM_UNITS = 3,
  parameter int ID_W      = 3,
  parameter int PAYLOAD_W = 72
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_UNITS-1:0]           unit_done,
  input  logic [NUM_UNITS*ID_W-1:0]      unit_id,
  input  logic [NUM_UNITS*PAYLOAD_W-1:0] unit_payload,
  output logic [NUM_UNITS-1:0]           unit_ack,
  output logic                           out_valid,
  output logic [ID_W-1:0]                out_id,
  output logic [PAYLOAD_W-1:0]           out_payload,
  output logic [$clog2(NUM_UNITS)-1:0]   out_unit,
  input  logic                           out_ready
);

  localparam int UNIT_W = $clog2(NUM_UNITS);

  logic [UNIT_W-1:0]    r_ptr;
  logic                 w_found;
  logic [UNIT_W-1:0]    w_gnt;
  logic [UNIT_W-1:0]    w_cand;
  logic [NUM_UNITS-1:0] w_sel;
  logic                 w_accept;
  logic                 w_ack;
  logic [ID_W-1:0]      w_id;
  logic [PAYLOAD_W-1:0] w_payload;

  // Search ptr, ptr+1, ... (mod NUM_UNITS); the first pending producer wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cand  = '0;
    w_sel   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (int'(r_ptr) + k < NUM_UNITS) w_cand = UNIT_W'(int'(r_ptr) + k);
      else                             w_cand = UNIT_W'(int'(r_ptr) + k - NUM_UNITS);
      w_sel = unit_done >> w_cand;
      if (!w_found && w_sel[0]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  // The reset term keeps unit_ack low for as long as rst is asserted,
  // not just from the next clock edge.
  assign w_ack     = w_found & w_accept & ~rst;
  assign unit_ack  = w_ack ? (NUM_UNITS'(1) << w_gnt) : '0;
  assign w_id      = unit_id[int'(w_gnt)*ID_W +: ID_W];
  assign w_payload = unit_payload[int'(w_gnt)*PAYLOAD_W +: PAYLOAD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_ack) begin
      r_ptr <= (int'(w_gnt) == NUM_UNITS-1) ? '0 : w_gnt + 1'b1;
    end
  end

`ifdef FP_WB_ARB_SKID_EN
  // 2-entry FIFO. Acceptance looks only at the registered occupancy, so
  // unit_ack never depends on out_ready. With one entry held, a push and a
  // pop can happen in the same cycle, which sustains one result per cycle.
  logic [ID_W-1:0]      r_fid   [2];
  logic [PAYLOAD_W-1:0] r_fpay  [2];
  logic [UNIT_W-1:0]    r_funit [2];
  logic                 r_wp;
  logic                 r_rp;
  logic [1:0]           r_cnt;
  logic                 w_pop;

  assign w_pop    = (r_cnt != 2'd0) & out_ready;
  assign w_accept = (r_cnt != 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_ack) r_wp <= ~r_wp;
      if (w_pop) r_rp <= ~r_rp;
      case ({w_ack, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ack) begin
      r_fid[r_wp]   <= w_id;
      r_fpay[r_wp]  <= w_payload;
      r_funit[r_wp] <= w_gnt;
    end
  end

  assign out_valid   = (r_cnt != 2'd0);
  assign out_id      = r_fid[r_rp];
  assign out_payload = r_fpay[r_rp];
  assign out_unit    = r_funit[r_rp];
`else
  // Single output register. It advances when it is empty or being consumed,
  // so a new result can follow a consumed one with no bubble.
  logic                 r_valid;
  logic [ID_W-1:0]      r_id;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [UNIT_W-1:0]    r_unit;

  assign w_accept = ~r_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= w_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ack) begin
      r_id      <= w_id;
      r_payload <= w_payload;
      r_unit    <= w_gnt;
    end
  end

  assign out_valid   = r_valid;
  assign out_id      = r_id;
  assign out_payload = r_payload;
  assign out_unit    = r_unit;
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
module tb_fp_wb_arbiter;

  localparam int NU = 3;
  localparam int IW = 3;
  localparam int PW = 72;

`ifdef FP_WB_ARB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] pl;
    logic [1:0]    unit;
  } item_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NU-1:0]    unit_done;
  logic [NU*IW-1:0] unit_id;
  logic [NU*PW-1:0] unit_payload;
  logic [NU-1:0]    unit_ack;
  logic             out_valid;
  logic [IW-1:0]    out_id;
  logic [PW-1:0]    out_payload;
  logic [1:0]       out_unit;
  logic             out_ready;

  fp_wb_arbiter #(.NUM_UNITS(NU), .ID_W(IW), .PAYLOAD_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .unit_done    (unit_done),
    .unit_id      (unit_id),
    .unit_payload (unit_payload),
    .unit_ack     (unit_ack),
    .out_valid    (out_valid),
    .out_id       (out_id),
    .out_payload  (out_payload),
    .out_unit     (out_unit),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  item_t pq [NU][$];   // pending items per producer, head is presented
  item_t sb [$];       // results acked and not yet consumed, in ack order
  int    mptr;
  int    n_chk = 0;
  int    n_err = 0;
  int    ack_cnt;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input int u, input logic [IW-1:0] id, input logic [PW-1:0] pl);
    item_t it;
    it.id   = id;
    it.pl   = pl;
    it.unit = 2'(u);
    return it;
  endfunction

  task automatic push_rand(input int u);
    logic [PW-1:0] pl;
    pl = {8'($urandom), $urandom, $urandom};
    pq[u].push_back(mk(u, IW'($urandom), pl));
  endtask

  task automatic drive();
    for (int i = 0; i < NU; i++) begin
      if (pq[i].size() != 0) begin
        unit_done[i]            = 1'b1;
        unit_id[i*IW +: IW]     = pq[i][0].id;
        unit_payload[i*PW +: PW] = pq[i][0].pl;
      end else begin
        unit_done[i] = 1'b0;
      end
    end
  endtask

  // One clock: check against the model at the falling edge, then advance the
  // model past the rising edge and present the next producer heads.
  task automatic step();
    int            g;
    logic          can;
    logic [NU-1:0] eack;
    logic          pop_e;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NU; k++) begin
      if (g < 0 && pq[(mptr + k) % NU].size() != 0) g = (mptr + k) % NU;
    end
    if (DEPTH == 2) can = (sb.size() < 2);
    else            can = (sb.size() == 0) || out_ready;
    eack = (g >= 0 && can) ? NU'(1 << g) : '0;
    check("ack", 128'(unit_ack), 128'(eack));
    check("valid", 128'(out_valid), 128'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_id", 128'(out_id), 128'(sb[0].id));
      check("out_payload", 128'(out_payload), 128'(sb[0].pl));
      check("out_unit", 128'(out_unit), 128'(sb[0].unit));
    end
    ack_cnt += $countones(unit_ack);
    pop_e = (sb.size() != 0) && out_ready;
    @(posedge clk);
    #1;
    if (pop_e) void'(sb.pop_front());
    if (eack != '0) begin
      sb.push_back(pq[g].pop_front());
      mptr = (g + 1) % NU;
    end
    drive();
  endtask

  task automatic drain(input string tag);
    int left;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (sb.size() == 0 && pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0) break;
      step();
    end
    left = sb.size() + pq[0].size() + pq[1].size() + pq[2].size();
    check(tag, 128'(left), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    out_ready    = 1'b0;
    unit_done    = '0;
    unit_id      = '0;
    unit_payload = '0;
    mptr         = 0;
    ack_cnt      = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 128'(out_valid), 128'(0));
    check("reset_ack", 128'(unit_ack), 128'(0));
    rst = 1'b0;

    // Idle after reset.
    repeat (10) step();
    check("idle_ptr", 128'(dut.r_ptr), 128'(0));

    // All producers done with full throughput: acks 1,2,4,1,2,4.
    out_ready = 1'b1;
    for (int i = 0; i < NU; i++) begin
      push_rand(i);
      push_rand(i);
    end
    drive();
    ack_cnt = 0;
    repeat (6) step();
    check("rr_acks", 128'(ack_cnt), 128'(6));
    repeat (2) step();
    check("rr_ptr", 128'(dut.r_ptr), 128'(0));

    // Single producer 1 with a known result.
    pq[1].push_back(mk(1, 3'd5, 72'h1234));
    drive();
    step();
    check("single_ptr", 128'(dut.r_ptr), 128'(2));
    step();
    drain("single_drain");

    // Back-pressure with three producers done.
    out_ready = 1'b0;
    for (int i = 0; i < NU; i++) push_rand(i);
    drive();
    ack_cnt = 0;
    repeat (5) step();
    check("stall_acks", 128'(ack_cnt), 128'(DEPTH));
    drain("stall_drain");

    // Random traffic and back-pressure.
    repeat (300) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NU; i++)
        if (pq[i].size() < 2 && $urandom_range(0, 2) == 0) push_rand(i);
      drive();
      step();
    end
    drain("rand_drain");

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    push_rand(1);
    push_rand(1);
    drive();
    step();
    step();
    check("pre_rst_valid", 128'(out_valid), 128'(1));
    check("pre_rst_ptr", 128'(dut.r_ptr), 128'(2));
    rst = 1'b1;
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_ack", 128'(unit_ack), 128'(0));
    check("rst_ptr", 128'(dut.r_ptr), 128'(0));
    sb.delete();
    mptr = 0;
    @(negedge clk);
    check("rst_hold_ack", 128'(unit_ack), 128'(0));
    check("rst_hold_valid", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_rand(2);
    out_ready = 1'b1;
    drive();
    repeat (4) step();
    drain("post_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
